// File: rtl/pipe_defs.sv
// Shared pipeline definitions: control-bit layout and ALU op encodings.
// Used by the decoder, the ID/EX register and the EX/MEM register.
package pipe_defs;

  localparam int unsigned CTRL_W         = 6;
  localparam int unsigned CTRL_REG_WRITE = 5;
  localparam int unsigned CTRL_MEM_READ  = 4;
  localparam int unsigned CTRL_MEM_WRITE = 3;
  localparam int unsigned CTRL_MEM_TO_REG = 2;
  localparam int unsigned CTRL_ALU_SRC   = 1;
  localparam int unsigned CTRL_REG_DST   = 0;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8,
    ALU_SRA = 4'h9,
    ALU_LUI = 4'hA
  } alu_op_e;

  typedef logic [CTRL_W-1:0] ctrl_t;

  function automatic ctrl_t ctrl_pack(input logic reg_write, input logic mem_read,
                                      input logic mem_write, input logic mem_to_reg,
                                      input logic alu_src, input logic reg_dst);
    ctrl_t c;
    c                  = '0;
    c[CTRL_REG_WRITE]  = reg_write;
    c[CTRL_MEM_READ]   = mem_read;
    c[CTRL_MEM_WRITE]  = mem_write;
    c[CTRL_MEM_TO_REG] = mem_to_reg;
    c[CTRL_ALU_SRC]    = alu_src;
    c[CTRL_REG_DST]    = reg_dst;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID->EX bundle and handshake. "slave" is the stage register's view,
// "master" is the surrounding pipeline (ID producer + EX consumer).
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 4
);
  import pipe_defs::*;

  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [DATA_W-1:0]   in_pc4;
  logic [DATA_W-1:0]   in_rs_data;
  logic [DATA_W-1:0]   in_rt_data;
  logic [DATA_W-1:0]   in_imm_ext;
  logic [DATA_W-1:0]   in_shamt_ext;
  logic [REG_AW-1:0]   in_rs;
  logic [REG_AW-1:0]   in_rt;
  logic [REG_AW-1:0]   in_rd;
  logic [ALUOP_W-1:0]  in_alu_op;
  logic [CTRL_W-1:0]   in_ctrl;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_pc4;
  logic [DATA_W-1:0]   out_rs_data;
  logic [DATA_W-1:0]   out_rt_data;
  logic [DATA_W-1:0]   out_imm_ext;
  logic [DATA_W-1:0]   out_shamt_ext;
  logic [REG_AW-1:0]   out_rs;
  logic [REG_AW-1:0]   out_rt;
  logic [REG_AW-1:0]   out_rd;
  logic [ALUOP_W-1:0]  out_alu_op;
  logic [CTRL_W-1:0]   out_ctrl;

  modport slave (
    input  in_valid, flush, in_pc4, in_rs_data, in_rt_data, in_imm_ext, in_shamt_ext,
           in_rs, in_rt, in_rd, in_alu_op, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc4, out_rs_data, out_rt_data, out_imm_ext,
           out_shamt_ext, out_rs, out_rt, out_rd, out_alu_op, out_ctrl
  );

  modport master (
    output in_valid, flush, in_pc4, in_rs_data, in_rt_data, in_imm_ext, in_shamt_ext,
           in_rs, in_rt, in_rd, in_alu_op, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc4, out_rs_data, out_rt_data, out_imm_ext,
           out_shamt_ext, out_rs, out_rt, out_rd, out_alu_op, out_ctrl
  );

endinterface

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async active-low reset to zero, load enable.
module pipe_field_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] field_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      field_q <= '0;
    end else if (en_i) begin
      field_q <= d_i;
    end
  end

  assign q_o = field_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake and redirect flush.
// Control bits are cleared whenever the stage goes empty so bubbles never store/write back.
module id_ex_stage_reg
  import pipe_defs::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 4
) (
  input logic              Clk,
  input logic              Rst_n,
  id_ex_stage_reg_if.slave bus
);

  localparam int unsigned DATA_GRP_W = 5 * DATA_W;
  localparam int unsigned IDX_GRP_W  = 3 * REG_AW + ALUOP_W;

  logic valid_q;
  logic valid_d;
  logic load;
  logic take;
  logic ctrl_en;

  logic [DATA_GRP_W-1:0] data_d;
  logic [DATA_GRP_W-1:0] data_q;
  logic [IDX_GRP_W-1:0]  idx_d;
  logic [IDX_GRP_W-1:0]  idx_q;
  logic [CTRL_W-1:0]     ctrl_d;
  logic [CTRL_W-1:0]     ctrl_q;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;
  // A flushed bundle is still handshaken on the input side but never captured.
  assign take         = load && !bus.flush;

  always_comb begin
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign data_d  = {bus.in_pc4, bus.in_rs_data, bus.in_rt_data, bus.in_imm_ext, bus.in_shamt_ext};
  assign idx_d   = {bus.in_rs, bus.in_rt, bus.in_rd, bus.in_alu_op};
  // Ctrl reloads on every valid transition; zero unless a bundle is actually taken.
  assign ctrl_en = bus.flush || load || (valid_q && bus.out_ready);
  assign ctrl_d  = take ? bus.in_ctrl : '0;

  pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .en_i   (take),
    .d_i    (data_d),
    .q_o    (data_q)
  );

  pipe_field_reg #(.W(IDX_GRP_W)) u_idx_reg (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .en_i   (take),
    .d_i    (idx_d),
    .q_o    (idx_q)
  );

  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .en_i   (ctrl_en),
    .d_i    (ctrl_d),
    .q_o    (ctrl_q)
  );

  assign bus.out_valid = valid_q;
  assign {bus.out_pc4, bus.out_rs_data, bus.out_rt_data, bus.out_imm_ext, bus.out_shamt_ext} = data_q;
  assign {bus.out_rs, bus.out_rt, bus.out_rd, bus.out_alu_op} = idx_q;
  assign bus.out_ctrl = ctrl_q;

endmodule
